// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: strobes columns from a free-running divider,
// samples synchronized rows, debounces over whole scans, emits one code per press.
module keypad_scan #(
  parameter int unsigned SCAN_BITS      = 16,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int unsigned CNT_W = (DEBOUNCE_SCANS < 2) ? 1 : $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_HELD,
    S_RELEASE
  } state_t;

  logic [SCAN_BITS-1:0] r_div;
  logic [1:0]           r_col;
  logic [3:0]           r_sync1;
  logic [3:0]           r_rows_s;
  logic [1:0]           r_acc_cnt;
  logic [3:0]           r_acc_code;
  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [3:0]           r_cand;

  logic                 w_tick;
  logic                 w_scan_end;
  logic [1:0]           w_col_nxt;
  logic [3:0]           w_hit;
  logic [2:0]           w_col_sum;
  logic [1:0]           w_col_num;
  logic [2:0]           w_tot;
  logic [1:0]           w_sum_cnt;
  logic [1:0]           w_first_row;
  logic [3:0]           w_col_code;
  logic [3:0]           w_sum_code;
  logic                 w_none;
  logic                 w_single;
  logic [CNT_W-1:0]     w_cnt_inc;
  logic                 w_cnt_done;

  state_t               w_state_nxt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [3:0]           w_cand_nxt;
  logic [3:0]           w_code_nxt;
  logic                 w_valid_nxt;
  logic                 w_down_nxt;

  assign w_tick     = &r_div;
  assign w_scan_end = w_tick && (r_col == 2'd3);
  assign w_col_nxt  = r_col + 2'd1;

  // Divider, column strobe and row synchronizer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div    <= '0;
      r_col    <= 2'd0;
      col_out  <= 4'b1110;
      r_sync1  <= 4'b1111;
      r_rows_s <= 4'b1111;
    end else begin
      r_div    <= r_div + SCAN_BITS'(1);
      r_sync1  <= row_in;
      r_rows_s <= r_sync1;
      if (w_tick) begin
        r_col   <= w_col_nxt;
        col_out <= ~(4'b0001 << w_col_nxt);
      end
    end
  end

  // Per-column hit count and first hit, merged into the running scan result
  assign w_hit     = ~r_rows_s;
  assign w_col_sum = 3'(w_hit[0]) + 3'(w_hit[1]) + 3'(w_hit[2]) + 3'(w_hit[3]);
  assign w_col_num = (w_col_sum > 3'd1) ? 2'd2 : w_col_sum[1:0];
  assign w_tot     = 3'(r_acc_cnt) + 3'(w_col_num);
  assign w_sum_cnt = (w_tot > 3'd1) ? 2'd2 : w_tot[1:0];

  always_comb begin
    w_first_row = 2'd0;
    if (w_hit[0])      w_first_row = 2'd0;
    else if (w_hit[1]) w_first_row = 2'd1;
    else if (w_hit[2]) w_first_row = 2'd2;
    else if (w_hit[3]) w_first_row = 2'd3;
  end

  assign w_col_code = {w_first_row, r_col};
  assign w_sum_code = (r_acc_cnt == 2'd0) ? w_col_code : r_acc_code;
  assign w_none     = (w_sum_cnt == 2'd0);
  assign w_single   = (w_sum_cnt == 2'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc_cnt  <= 2'd0;
      r_acc_code <= 4'd0;
    end else if (w_scan_end) begin
      r_acc_cnt  <= 2'd0;
      r_acc_code <= 4'd0;
    end else if (w_tick) begin
      r_acc_cnt  <= w_sum_cnt;
      r_acc_code <= w_sum_code;
    end
  end

  // Debounce FSM state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_cand    <= 4'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_cand    <= w_cand_nxt;
      key_code  <= w_code_nxt;
      key_valid <= w_valid_nxt;
      key_down  <= w_down_nxt;
    end
  end

  assign w_cnt_inc  = r_cnt + CNT_W'(1);
  assign w_cnt_done = (w_cnt_inc == CNT_W'(DEBOUNCE_SCANS));

  // Next-state logic; the FSM only moves on a scan end
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cand_nxt  = r_cand;
    w_code_nxt  = key_code;
    w_valid_nxt = 1'b0;
    w_down_nxt  = key_down;
    if (w_scan_end) begin
      case (r_state)
        S_IDLE: begin
          if (w_single) begin
            if (DEBOUNCE_SCANS <= 1) begin
              w_state_nxt = S_HELD;
              w_code_nxt  = w_sum_code;
              w_valid_nxt = 1'b1;
              w_down_nxt  = 1'b1;
              w_cnt_nxt   = '0;
            end else begin
              w_state_nxt = S_DEBOUNCE;
              w_cand_nxt  = w_sum_code;
              w_cnt_nxt   = CNT_W'(1);
            end
          end
        end
        S_DEBOUNCE: begin
          if (w_single && (w_sum_code == r_cand)) begin
            if (w_cnt_done) begin
              w_state_nxt = S_HELD;
              w_code_nxt  = r_cand;
              w_valid_nxt = 1'b1;
              w_down_nxt  = 1'b1;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end else begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end
        end
        S_HELD: begin
          if (w_none) begin
            if (DEBOUNCE_SCANS <= 1) begin
              w_state_nxt = S_IDLE;
              w_down_nxt  = 1'b0;
              w_cnt_nxt   = '0;
            end else begin
              w_state_nxt = S_RELEASE;
              w_cnt_nxt   = CNT_W'(1);
            end
          end
        end
        S_RELEASE: begin
          if (w_none) begin
            if (w_cnt_done) begin
              w_state_nxt = S_IDLE;
              w_down_nxt  = 1'b0;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end else begin
            w_state_nxt = S_HELD;
            w_cnt_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan: a keypad model drives rows from col_out,
// and each test runs whole scans while counting key_valid pulses.
module tb_keypad_scan;

  localparam int unsigned SB   = 2;
  localparam int unsigned DS   = 2;
  localparam int          SCAN = 4 * (1 << SB);

  logic       clk;
  logic       rst;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  logic [15:0] keys;

  int n_checks;
  int n_pass;
  int pulses;
  int pulse_at;
  int pulse_code;
  int down_min;

  keypad_scan #(.SCAN_BITS(SB), .DEBOUNCE_SCANS(DS)) dut (
    .clk      (clk),
    .rst      (rst),
    .row_in   (row_in),
    .col_out  (col_out),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_down (key_down)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad model: key (r,c) pulls row r low while column c is driven low
  always_comb begin
    for (int r = 0; r < 4; r++) row_in[r] = ~|(keys[4*r +: 4] & ~col_out);
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
  endtask

  // Run n scans from a scan boundary, sampling 1 time unit after each edge
  task automatic run_scans(input int n);
    pulses     = 0;
    pulse_at   = -1;
    pulse_code = -1;
    down_min   = 1;
    for (int i = 1; i <= n * SCAN; i++) begin
      @(posedge clk);
      #1;
      if (key_valid) begin
        pulses++;
        if (pulse_at < 0) begin
          pulse_at   = i;
          pulse_code = int'(key_code);
        end
      end
      if (!key_down) down_min = 0;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    keys     = 16'h0000;
    rst      = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check_eq("rst_col_out", int'(col_out), 4'b1110);
    check_eq("rst_code", int'(key_code), 0);
    check_eq("rst_valid", int'(key_valid), 0);
    check_eq("rst_down", int'(key_down), 0);

    // Column walk through the first (empty) scan
    for (int i = 1; i <= SCAN; i++) begin
      @(posedge clk);
      #1;
      case (i)
        3:  check_eq("walk_e3", int'(col_out), 4'b1110);
        4:  check_eq("walk_e4", int'(col_out), 4'b1101);
        8:  check_eq("walk_e8", int'(col_out), 4'b1011);
        12: check_eq("walk_e12", int'(col_out), 4'b0111);
        16: check_eq("walk_e16", int'(col_out), 4'b1110);
        default: ;
      endcase
    end

    // Clean press of key 9 (row 2, col 1) for 6 scans
    keys = 16'h0000;
    keys[9] = 1'b1;
    run_scans(6);
    check_eq("clean_pulses", pulses, 1);
    check_eq("clean_pulse_at", pulse_at, 2 * SCAN);
    check_eq("clean_code", pulse_code, 9);
    check_eq("clean_down", int'(key_down), 1);

    keys = 16'h0000;
    run_scans(1);
    check_eq("rel9_down_s1", int'(key_down), 1);
    run_scans(1);
    check_eq("rel9_down_s2", int'(key_down), 0);

    // Bounce: key present for a single scan only
    keys[9] = 1'b1;
    run_scans(1);
    keys = 16'h0000;
    run_scans(2);
    check_eq("bounce_pulses", pulses, 0);
    check_eq("bounce_down", int'(key_down), 0);

    // Ghost: keys 0 and 15 together, then only key 0
    keys = 16'h0000;
    keys[0]  = 1'b1;
    keys[15] = 1'b1;
    run_scans(4);
    check_eq("multi_pulses", pulses, 0);
    check_eq("multi_down", int'(key_down), 0);
    keys[15] = 1'b0;
    run_scans(2);
    check_eq("single0_pulses", pulses, 1);
    check_eq("single0_code", pulse_code, 0);
    check_eq("single0_down", int'(key_down), 1);
    keys = 16'h0000;
    run_scans(2);
    check_eq("rel0_down", int'(key_down), 0);

    // Release/re-press of key 5
    keys[5] = 1'b1;
    run_scans(2);
    check_eq("k5_pulses", pulses, 1);
    check_eq("k5_code", pulse_code, 5);
    keys = 16'h0000;
    run_scans(1);
    check_eq("k5_short_rel_down", down_min, 1);
    keys[5] = 1'b1;
    run_scans(2);
    check_eq("k5_repress_pulses", pulses, 0);
    check_eq("k5_repress_down", down_min, 1);
    keys = 16'h0000;
    keys[6] = 1'b1;
    run_scans(3);
    check_eq("held_other_pulses", pulses, 0);
    check_eq("held_other_code", int'(key_code), 5);
    keys = 16'h0000;
    run_scans(2);
    check_eq("k5_rel_down", int'(key_down), 0);
    keys[5] = 1'b1;
    run_scans(2);
    check_eq("k5_second_pulses", pulses, 1);
    check_eq("k5_second_code", pulse_code, 5);
    keys = 16'h0000;
    run_scans(2);
    check_eq("k5_final_rel", int'(key_down), 0);

    // Reset mid-debounce on key 15
    keys[15] = 1'b1;
    run_scans(1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("mid_rst_valid", int'(key_valid), 0);
    check_eq("mid_rst_col_out", int'(col_out), 4'b1110);
    rst = 1'b0;
    run_scans(1);
    check_eq("post_rst_s1_pulses", pulses, 0);
    run_scans(1);
    check_eq("post_rst_s2_pulses", pulses, 1);
    check_eq("post_rst_pulse_at", pulse_at, SCAN);
    check_eq("post_rst_code", pulse_code, 15);
    check_eq("post_rst_down", int'(key_down), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
